mul_hilo_stage: RTL

//  Sequencing and writeback stage around the combinational 32x32 signed Booth multiplier.
//  - Holds the operands stable on the multiplier inputs for a programmable settle time.
//  - Captures the 64-bit product into architectural HI/LO registers.
//  - Sits between the ID/EX operand path and the HI/LO read path (mfhi/mflo).
//  - Also services direct HI/LO writes (mthi/mtlo).

---
 rtl/mul_hilo_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mul_hilo_stage.sv
// ---------------------------------------------------------------------------
// mul_hilo_stage
//
// Sequencing and writeback stage wrapped around a combinational 32x32 signed
// multiplier. It latches the operands onto the multiplier inputs, holds them
// for LATENCY settle cycles, then captures the 64-bit product into the
// architectural HI/LO registers. It also services direct HI/LO writes
// (mthi/mtlo) while no multiply is in flight.
//
// Parameters
//   LATENCY     settle cycles before capture, legal range 1..15
//
// Optional feature
//   MUL_OVERFLOW_FLAG_EN  when defined, `overflow` reports whether the last
//                         captured product fits in 32 signed bits. When
//                         undefined, `overflow` is tied to 0 and the port
//                         list is unchanged.
//
// Ports
//   clock       in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   start       in   1   request a multiply (sampled only in IDLE)
//   op_a        in   32  multiplicand (signed)
//   op_b        in   32  multiplier (signed)
//   mul_Q       out  32  operand register feeding the multiplier _Q input
//   mul_M       out  32  operand register feeding the multiplier _M input
//   mul_result  in   64  product returned by the multiplier
//   HI_in       in   32  direct write data for HI
//   LO_in       in   32  direct write data for LO
//   HI_write    in   1   direct HI write enable (IDLE only)
//   LO_write    in   1   direct LO write enable (IDLE only)
//   busy        out  1   high in WAIT and CAPTURE
//   done        out  1   one-cycle pulse in the cycle HI/LO hold the product
//   HI_out      out  32  HI register
//   LO_out      out  32  LO register
//   overflow    out  1   captured product does not fit in 32 signed bits
// ---------------------------------------------------------------------------
module mul_hilo_stage #(
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mul_Q,
  output logic [31:0] mul_M,
  input  logic [63:0] mul_result,
  input  logic [31:0] HI_in,
  input  logic [31:0] LO_in,
  input  logic        HI_write,
  input  logic        LO_write,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // Reload value for the settle counter. WAIT is left when the counter reads
  // zero, so loading LATENCY-1 gives exactly LATENCY WAIT cycles.
  localparam logic [3:0] COUNT_RELOAD = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] mul_q_q, mul_q_d;
  logic [31:0] mul_m_q, mul_m_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef MUL_OVERFLOW_FLAG_EN
  logic        overflow_q, overflow_d;
  logic        product_overflows;

  // The product fits in 32 signed bits only when the upper word is a pure
  // sign extension of bit 31.
  assign product_overflows = (mul_result[63:32] != {32{mul_result[31]}});
`endif

  // -------------------------------------------------------------------------
  // Next-state and register-update logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    count_d = count_q;
    mul_q_d = mul_q_q;
    mul_m_d = mul_m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MUL_OVERFLOW_FLAG_EN
    overflow_d = overflow_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Direct writes land even when a start is accepted in the same cycle;
        // the later capture overwrites both registers anyway.
        if (HI_write) hi_d = HI_in;
        if (LO_write) lo_d = LO_in;
        if (start) begin
          mul_q_d = op_a;
          mul_m_d = op_b;
          count_d = COUNT_RELOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // start and direct writes are ignored here: nothing is queued.
        if (count_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end

      ST_CAPTURE: begin
        hi_d    = mul_result[63:32];
        lo_d    = mul_result[31:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef MUL_OVERFLOW_FLAG_EN
        overflow_d = product_overflows;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered from the next state so that it is already high in
    // the first WAIT cycle and already low in the cycle done pulses.
    busy_d = (state_d != ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      mul_q_q <= 32'd0;
      mul_m_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mul_q_q <= mul_q_d;
      mul_m_q <= mul_m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MUL_OVERFLOW_FLAG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mul_Q  = mul_q_q;
  assign mul_M  = mul_m_q;
  assign HI_out = hi_q;
  assign LO_out = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
